dice_turn_scheduler: RTL and testbench
======================================

Name: dice_turn_scheduler

Overview:
Turn sequencer for the two-player dice game. It shares one free-running dice roller and one 4-digit display between two player buttons. It grants turns, gates the roller, and latches each roll into per-player running scores. It declares the first player to reach TARGET the winner. It sits between the debouncers and the roller/display datapath.

Parameters:
TARGET, 50, winning score threshold (score >= TARGET wins)
SHOW_CYCLES, 4, cycles each roll result is held on the display before the turn passes
SCORE_W, 7, width of each score accumulator
TIMEOUT_CYCLES, 16, idle-turn limit (used only with TURN_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-low
btn_req  in  2  debounced player buttons, level-high while held; bit p = player p
dice_val  in  4  current roller output, valid range 2..12
roll_en  out  1  roller enable; high only while the granted player holds the button
grant  out  2  one-hot current player; 00 when no turn is active
disp_en  out  1  display enable
last_roll  out  4  most recently latched roll
score0  out  SCORE_W  player 0 score
score1  out  SCORE_W  player 1 score
winner  out  2  one-hot winner; 00 until the game ends
done  out  1  game-over flag
forfeit  out  1  one-cycle pulse on a timed-out turn

Behaviour:
- Reset (reset==0 at posedge) forces state IDLE, rr_ptr=0, and armed=0.
- Reset also clears all outputs: grant=00, roll_en=0, disp_en=0, last_roll=0, scores=0, winner=00, done=0, forfeit=0.
- Reset mid-operation aborts any turn with no score update.
- All outputs are registered, except roll_en, which is combinational: (state==ROLL) & btn_req[p].
- IDLE:
  - armed is set once btn_req==00 for at least one cycle.
  - When armed and btn_req!=00: p = the pressed player; if both bits are set, p = rr_ptr.
  - On that start, rr_ptr <= ~p, grant <= onehot(p), and next state is ROLL.
- TURN: grant held at onehot(p). btn_req[p]==1 moves to ROLL. btn_req[~p] is ignored in every state except IDLE.
- ROLL: roll_en=1 while btn_req[p]==1. On the first cycle with btn_req[p]==0, move to LATCH.
- LATCH (one cycle):
  - last_roll <= dice_val.
  - score[p] <= score[p] + dice_val, saturating at 2^SCORE_W-1.
  - dice_val outside 2..12 is treated as 0 for both last_roll and score.
  - disp_en <= 1; next state is SHOW.
- SHOW:
  - Lasts exactly SHOW_CYCLES cycles; the counter is cleared on entry.
  - Then, if score[p] >= TARGET: winner <= onehot(p), done <= 1, grant <= 00, next state OVER.
  - Otherwise p <= ~p, grant <= onehot(~p), next state TURN.
- OVER:
  - Scores, winner, last_roll and the display are held.
  - Any btn_req!=00 clears scores, winner, done, last_roll and disp_en, sets armed=0, and moves to IDLE.
  - A new game therefore needs a release followed by a press.
- Ties are impossible; only one score changes per turn.
- Latency: button release to score update is 2 clk edges (ROLL→LATCH, LATCH registers).

Optional Feature:
TURN_TIMEOUT_EN
- Defined:
  - In TURN, a counter counts cycles with btn_req[p]==0 and is cleared on entry to TURN.
  - When it reaches TIMEOUT_CYCLES, the turn is forfeited: forfeit pulses 1 cycle, last_roll <= 0, score unchanged, and the block goes to SHOW.
- Undefined: TURN waits indefinitely, and forfeit is tied to 0.

Test Plan:
1. Reset, then btn_req=00 for 1 cycle, then 01 for 3 cycles, then 00 with dice_val=7 -> grant=01, roll_en high exactly 3 cycles, score0=7, last_roll=7, grant=10 after 4 SHOW cycles.
2. After reset, btn_req=11 in one cycle -> player 0 wins the start. Play to OVER and restart with 11 again -> player 1 wins the start.
3. During player 0's turn, pulse btn_req[1] -> no roll_en, grant unchanged, score1 unchanged.
4. TARGET=10: player 0 rolls 6 then 5, player 1 rolls 3 -> after player 0's second roll, score0=11, winner=01, done=1, grant=00. Further presses clear the state and return to IDLE.
5. dice_val=15 latched -> last_roll=0 and score unchanged. With SCORE_W=4 and score 14, a roll of 12 -> score 15 (saturated).
6. With TURN_TIMEOUT_EN defined, granted player idle for 16 cycles -> forfeit pulse, score unchanged, turn passes. Assert reset mid-ROLL -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/dice_turn_scheduler.sv
// Turn sequencer for the two-player dice game: grants turns, gates the shared roller and keeps scores.
// Optional idle-turn forfeit is built when TURN_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a release, then a press to pick the first player
// TURN  | player p granted, waiting for the button
// ROLL  | roller running while player p holds the button
// LATCH | capture roll and update score[p]
// SHOW  | hold result on the display for SHOW_CYCLES cycles
// OVER  | game finished, results held until any press
module dice_turn_scheduler #(
    parameter int TARGET      = 50,
    parameter int SHOW_CYCLES = 4,
    parameter int SCORE_W     = 7
`ifdef TURN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         btn_req,
    input  logic [3:0]         dice_val,
    output logic               roll_en,
    output logic [1:0]         grant,
    output logic               disp_en,
    output logic [3:0]         last_roll,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [1:0]         winner,
    output logic               done,
    output logic               forfeit
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TURN  = 3'd1,
        ROLL  = 3'd2,
        LATCH = 3'd3,
        SHOW  = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam int SHOW_W = $clog2(SHOW_CYCLES + 1);
    localparam logic [SHOW_W-1:0] SHOW_LOAD = SHOW_W'(SHOW_CYCLES - 1);

    state_t              state;
    logic                cur;
    logic                rr_ptr;
    logic                armed;
    logic [SHOW_W-1:0]   show_cnt;

`ifdef TURN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]    tmo_cnt;
`endif

    logic [3:0]          roll_val;
    logic [SCORE_W-1:0]  cur_score;
    logic [SCORE_W:0]    sum;
    logic [SCORE_W-1:0]  next_score;
    logic                start_p;
    logic                cur_wins;

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    always_comb begin
        roll_val   = ((dice_val >= 4'd2) && (dice_val <= 4'd12)) ? dice_val : 4'd0;
        cur_score  = cur ? score1 : score0;
        sum        = {1'b0, cur_score} + (SCORE_W + 1)'(roll_val);
        next_score = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
        // simultaneous presses alternate who starts
        start_p    = (btn_req == 2'b11) ? rr_ptr : btn_req[1];
        cur_wins   = (int'(cur_score) >= TARGET);
    end

    assign roll_en = (state == ROLL) && btn_req[cur];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cur       <= 1'b0;
            rr_ptr    <= 1'b0;
            armed     <= 1'b0;
            show_cnt  <= '0;
            grant     <= 2'b00;
            disp_en   <= 1'b0;
            last_roll <= 4'd0;
            score0    <= '0;
            score1    <= '0;
            winner    <= 2'b00;
            done      <= 1'b0;
            forfeit   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            forfeit <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_req == 2'b00) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        cur    <= start_p;
                        rr_ptr <= ~start_p;
                        grant  <= onehot(start_p);
                        state  <= ROLL;
                    end
                end
                TURN: begin
                    if (btn_req[cur]) begin
                        state <= ROLL;
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (tmo_cnt == '0) begin
                        forfeit   <= 1'b1;
                        last_roll <= 4'd0;
                        show_cnt  <= SHOW_LOAD;
                        state     <= SHOW;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
`endif
                end
                ROLL: begin
                    if (!btn_req[cur]) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    last_roll <= roll_val;
                    if (cur) begin
                        score1 <= next_score;
                    end else begin
                        score0 <= next_score;
                    end
                    disp_en  <= 1'b1;
                    show_cnt <= SHOW_LOAD;
                    state    <= SHOW;
                end
                SHOW: begin
                    if (show_cnt != '0) begin
                        show_cnt <= show_cnt - 1'b1;
                    end else if (cur_wins) begin
                        winner <= onehot(cur);
                        done   <= 1'b1;
                        grant  <= 2'b00;
                        state  <= OVER;
                    end else begin
                        cur   <= ~cur;
                        grant <= onehot(~cur);
`ifdef TURN_TIMEOUT_EN
                        tmo_cnt <= TMO_LOAD;
`endif
                        state <= TURN;
                    end
                end
                OVER: begin
                    if (btn_req != 2'b00) begin
                        score0    <= '0;
                        score1    <= '0;
                        winner    <= 2'b00;
                        done      <= 1'b0;
                        last_roll <= 4'd0;
                        disp_en   <= 1'b0;
                        armed     <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dice_turn_scheduler.sv
// Bench for dice_turn_scheduler: unit 0 plays to TARGET=10, unit 1 (SCORE_W=4) exercises saturation.
module tb_dice_turn_scheduler;

    logic       clk = 1'b0;
    logic       reset_v   [2];
    logic [1:0] btn       [2];
    logic [3:0] dice      [2];
    logic       roll_en_v [2];
    logic [1:0] grant_v   [2];
    logic       disp_en_v [2];
    logic [3:0] last_v    [2];
    logic [1:0] winner_v  [2];
    logic       done_v    [2];
    logic       forfeit_v [2];
    logic [6:0] a_s0, a_s1;
    logic [3:0] b_s0, b_s1;

    int n_checks = 0;
    int n_pass   = 0;
    int m_sc [2][2];

    typedef struct {
        int pl;
        int last;
        int s0;
        int s1;
        int grant;
        int winner;
        int done;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    dice_turn_scheduler #(.TARGET(10)) dut_a (
        .clk(clk), .reset(reset_v[0]), .btn_req(btn[0]), .dice_val(dice[0]),
        .roll_en(roll_en_v[0]), .grant(grant_v[0]), .disp_en(disp_en_v[0]),
        .last_roll(last_v[0]), .score0(a_s0), .score1(a_s1),
        .winner(winner_v[0]), .done(done_v[0]), .forfeit(forfeit_v[0])
    );

    dice_turn_scheduler #(.SCORE_W(4)) dut_b (
        .clk(clk), .reset(reset_v[1]), .btn_req(btn[1]), .dice_val(dice[1]),
        .roll_en(roll_en_v[1]), .grant(grant_v[1]), .disp_en(disp_en_v[1]),
        .last_roll(last_v[1]), .score0(b_s0), .score1(b_s1),
        .winner(winner_v[1]), .done(done_v[1]), .forfeit(forfeit_v[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int score_of(input int u, input int pl);
        if (u == 0) return (pl != 0) ? int'(a_s1) : int'(a_s0);
        return (pl != 0) ? int'(b_s1) : int'(b_s0);
    endfunction

    function automatic int target_of(input int u);
        return (u == 0) ? 10 : 50;
    endfunction

    function automatic int max_of(input int u);
        return (u == 0) ? 127 : 15;
    endfunction

    task automatic check_zero(input int u, input string tag);
        check({tag, "_roll_en"}, int'(roll_en_v[u]), 0);
        check({tag, "_grant"},   int'(grant_v[u]),   0);
        check({tag, "_disp_en"}, int'(disp_en_v[u]), 0);
        check({tag, "_last"},    int'(last_v[u]),    0);
        check({tag, "_score0"},  score_of(u, 0),     0);
        check({tag, "_score1"},  score_of(u, 1),     0);
        check({tag, "_winner"},  int'(winner_v[u]),  0);
        check({tag, "_done"},    int'(done_v[u]),    0);
        check({tag, "_forfeit"}, int'(forfeit_v[u]), 0);
    endtask

    task automatic do_reset(input int u, input string tag);
        reset_v[u] = 1'b0;
        btn[u]     = 2'b00;
        dice[u]    = 4'd0;
        step(2);
        check_zero(u, tag);
        reset_v[u] = 1'b1;
        m_sc[u][0] = 0;
        m_sc[u][1] = 0;
    endtask

    // press with 'bits', hold for 'hold' cycles, release, and score the turn
    task automatic play_roll(input int u, input logic [1:0] bits, input int pl,
                             input int d, input int hold);
        exp_t e;
        int   v;
        int   cnt;
        v = (d >= 2 && d <= 12) ? d : 0;
        m_sc[u][pl] = (m_sc[u][pl] + v > max_of(u)) ? max_of(u) : m_sc[u][pl] + v;
        e.pl   = pl;
        e.last = v;
        e.s0   = m_sc[u][0];
        e.s1   = m_sc[u][1];
        if (m_sc[u][pl] >= target_of(u)) begin
            e.grant = 0; e.winner = 1 << pl; e.done = 1;
        end else begin
            e.grant = 1 << (1 - pl); e.winner = 0; e.done = 0;
        end
        sb.push_back(e);

        btn[u]  = bits;
        dice[u] = 4'(d);
        cnt = 0;
        for (int i = 0; i < hold; i++) begin
            step(1);
            if (roll_en_v[u]) cnt++;
            if (i == 0) check("grant_on_roll", int'(grant_v[u]), 1 << pl);
        end
        check("roll_en_cycles", cnt, hold);
        btn[u] = 2'b00;
        step(1);
        check("roll_en_released", int'(roll_en_v[u]), 0);
        step(1);

        e = sb.pop_front();
        check("score0", score_of(u, 0), e.s0);
        check("score1", score_of(u, 1), e.s1);
        check("last_roll", int'(last_v[u]), e.last);
        check("disp_en", int'(disp_en_v[u]), 1);
        step(3);
        check("grant_during_show", int'(grant_v[u]), 1 << e.pl);
        step(1);
        check("grant_after_show", int'(grant_v[u]), e.grant);
        check("winner", int'(winner_v[u]), e.winner);
        check("done", int'(done_v[u]), e.done);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int seen;
        for (int u = 0; u < 2; u++) begin
            reset_v[u] = 1'b0;
            btn[u]     = 2'b00;
            dice[u]    = 4'd0;
        end

        // single press, full turn
        do_reset(0, "rst_a");
        step(1);
        play_roll(0, 2'b01, 0, 7, 3);

`ifdef TURN_TIMEOUT_EN
        seen = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (forfeit_v[0]) begin
                seen = i;
                break;
            end
        end
        check("forfeit_after_idle", seen, 16);
        check("forfeit_last_roll", int'(last_v[0]), 0);
        check("forfeit_score1", score_of(0, 1), 0);
        step(1);
        check("forfeit_one_cycle", int'(forfeit_v[0]), 0);
        step(3);
        check("forfeit_turn_passes", int'(grant_v[0]), 1);
`else
        cnt = 0;
        repeat (24) begin
            step(1);
            if (forfeit_v[0] || roll_en_v[0]) cnt++;
        end
        check("idle_turn_no_forfeit", cnt, 0);
        check("idle_turn_waits", int'(grant_v[0]), 2);
`endif

        // simultaneous start, ignored opponent, win, restart
        do_reset(0, "rst_a2");
        step(1);
        play_roll(0, 2'b11, 0, 6, 2);
        play_roll(0, 2'b10, 1, 3, 2);
        btn[0] = 2'b10;
        cnt = 0;
        repeat (2) begin
            step(1);
            if (roll_en_v[0]) cnt++;
        end
        btn[0] = 2'b00;
        step(1);
        check("other_btn_roll_en", cnt, 0);
        check("other_btn_grant", int'(grant_v[0]), 1);
        check("other_btn_score1", score_of(0, 1), 3);
        play_roll(0, 2'b01, 0, 5, 4);
        step(3);
        check("over_winner", int'(winner_v[0]), 1);
        check("over_done", int'(done_v[0]), 1);
        check("over_score0", score_of(0, 0), 11);
        check("over_last", int'(last_v[0]), 5);
        check("over_disp_en", int'(disp_en_v[0]), 1);
        btn[0] = 2'b11;
        step(1);
        check_zero(0, "restart");
        m_sc[0][0] = 0;
        m_sc[0][1] = 0;
        step(2);
        check("no_start_unarmed", int'(grant_v[0]), 0);
        btn[0] = 2'b00;
        step(1);
        play_roll(0, 2'b11, 1, 4, 2);

        // reset in the middle of a roll
        btn[0] = 2'b01;
        step(2);
        check("roll_before_reset", int'(roll_en_v[0]), 1);
        reset_v[0] = 1'b0;
        step(1);
        check_zero(0, "mid_roll_reset");
        reset_v[0] = 1'b1;
        btn[0] = 2'b00;

        // invalid rolls and saturation on the narrow unit
        do_reset(1, "rst_b");
        step(1);
        play_roll(1, 2'b01, 0, 12, 2);
        play_roll(1, 2'b10, 1, 15, 2);
        play_roll(1, 2'b01, 0, 2, 2);
        play_roll(1, 2'b10, 1, 13, 2);
        play_roll(1, 2'b01, 0, 12, 2);
        check("saturated_score0", score_of(1, 0), 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
